// File: rtl/alarm_ringer.sv
// Alarm response controller: turns the comparator's alarm window into buzzer drive,
// with snooze, dismiss and ring-timeout handling.
module alarm_ringer #(
    parameter int unsigned BEEP_HALF    = 25000000,
    parameter int unsigned SNOOZE_SEC   = 300,
    parameter int unsigned RING_MAX_SEC = 60,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic       clk_ar,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       alarm_in,
    input  logic       alarm_en,
    input  logic       dismiss,
    input  logic       snooze,
    output logic       ot_ar,
    output logic       ringing,
    output logic       snoozing,
    output logic [3:0] snooze_cnt
);

    localparam int unsigned SEC_W  = 16;
    localparam int unsigned BEEP_W = 26;
    localparam int unsigned SNZ_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RING,
        ST_SNOOZE,
        ST_LOCKOUT
    } state_t;

    state_t             state_q, state_d;
    logic               alarm_d_q;
    logic               ot_q, ot_d;
    logic               ringing_q, ringing_d;
    logic               snoozing_q, snoozing_d;
    logic [SNZ_W-1:0]   snooze_cnt_q, snooze_cnt_d;
    logic [SEC_W-1:0]   ring_sec_q, ring_sec_d;
    logic [SEC_W-1:0]   snz_sec_q, snz_sec_d;
    logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_d;
    logic               rise_c;
    logic               beep_wrap_c;

    assign rise_c      = alarm_in & ~alarm_d_q;
    assign beep_wrap_c = (beep_cnt_q == BEEP_W'(BEEP_HALF - 1));

    // State and counter registers; alarm_d resets high so a live window at release is not a rise.
    always_ff @(posedge clk_ar or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            alarm_d_q    <= 1'b1;
            ot_q         <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
            snooze_cnt_q <= '0;
            ring_sec_q   <= '0;
            snz_sec_q    <= '0;
            beep_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            alarm_d_q    <= alarm_in;
            ot_q         <= ot_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
            snooze_cnt_q <= snooze_cnt_d;
            ring_sec_q   <= ring_sec_d;
            snz_sec_q    <= snz_sec_d;
            beep_cnt_q   <= beep_cnt_d;
        end
    end

    // Next-state and output logic; buzzer is forced low outside RING.
    always_comb begin
        state_d      = state_q;
        ot_d         = 1'b0;
        snooze_cnt_d = snooze_cnt_q;
        ring_sec_d   = ring_sec_q;
        snz_sec_d    = snz_sec_q;
        beep_cnt_d   = beep_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (rise_c && alarm_en) begin
                    state_d      = ST_RING;
                    ot_d         = 1'b1;
                    beep_cnt_d   = '0;
                    ring_sec_d   = '0;
                    snooze_cnt_d = '0;
                end
            end
            ST_RING: begin
                if (dismiss || !alarm_en) begin
                    state_d = ST_LOCKOUT;
                end else if (snooze && (snooze_cnt_q < SNZ_W'(MAX_SNOOZE))) begin
                    state_d      = ST_SNOOZE;
                    snz_sec_d    = SEC_W'(SNOOZE_SEC);
                    snooze_cnt_d = snooze_cnt_q + SNZ_W'(1);
                end else if (sec_tick && (ring_sec_q == SEC_W'(RING_MAX_SEC - 1))) begin
                    state_d = ST_LOCKOUT;
                end else begin
                    if (sec_tick) begin
                        ring_sec_d = ring_sec_q + SEC_W'(1);
                    end
                    ot_d       = beep_wrap_c ? ~ot_q : ot_q;
                    beep_cnt_d = beep_wrap_c ? '0 : beep_cnt_q + BEEP_W'(1);
                end
            end
            ST_SNOOZE: begin
                if (dismiss || !alarm_en) begin
                    state_d = ST_LOCKOUT;
                end else if (sec_tick) begin
                    if (snz_sec_q == SEC_W'(1)) begin
                        state_d    = ST_RING;
                        ot_d       = 1'b1;
                        beep_cnt_d = '0;
                        ring_sec_d = '0;
                    end else begin
                        snz_sec_d = snz_sec_q - SEC_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                if (!alarm_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ringing_d  = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
    end

    assign ot_ar      = ot_q;
    assign ringing    = ringing_q;
    assign snoozing   = snoozing_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule
